// File: rtl/peasant_dot_acc.sv
// Dot-product accumulator behind the shift-add multiplier: sums LEN products
// captured on rising edges of the done flag and offers the sum over valid/ready.
module peasant_dot_acc #(
    parameter int N   = 16,
    parameter int LEN = 8,
    parameter int G   = 4,
    localparam int AW = 2*N + G,
    localparam int CW = $clog2(LEN + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fl_i,
    input  logic [2*N-1:0]  prod_i,
    input  logic            clear_i,
    output logic [AW-1:0]   sum_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [CW-1:0]   cnt_o,
    output logic            ovf_o,
    output logic            drop_o,
    output logic            busy_o
);

    localparam logic [0:0]    ST_ACC  = 1'b0;
    localparam logic [0:0]    ST_HOLD = 1'b1;
    localparam logic [CW-1:0] LEN_C   = CW'(LEN);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] sum_q, sum_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          drop_q, drop_d;
    logic          fl_q;

    logic          accept;
    logic          transfer;
    logic          restart;
    logic [AW-1:0] prodExt;
    logic [AW-1:0] addBase;
    logic [CW-1:0] cntBase;
    logic [CW-1:0] cntInc;
    logic [AW:0]   addFull;

    assign accept   = fl_i & ~fl_q;
    assign transfer = valid_q & ready_i;
    assign restart  = (state_q == ST_HOLD) & transfer;
    assign prodExt  = AW'(prod_i);

    // A transfer in the same cycle as an accept starts the next vector from zero.
    assign addBase  = restart ? '0 : acc_q;
    assign cntBase  = restart ? '0 : cnt_q;
    assign addFull  = {1'b0, addBase} + {1'b0, prodExt};
    assign cntInc   = cntBase + CW'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (clear_i) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
        end else begin
            if (restart) begin
                state_d = ST_ACC;
                acc_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
                ovf_d   = 1'b0;
            end

            if (accept) begin
                if ((state_q == ST_ACC) || restart) begin
                    // A carry out of the full-width add pins the accumulator at all ones.
                    acc_d = addFull[AW] ? '1 : addFull[AW-1:0];
                    ovf_d = (restart ? 1'b0 : ovf_q) | addFull[AW];
                    cnt_d = cntInc;
                    if (cntInc == LEN_C) begin
                        state_d = ST_HOLD;
                        sum_d   = acc_d;
                        valid_d = 1'b1;
                    end
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            fl_q    <= fl_i;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;
    assign ovf_o   = ovf_q;
    assign drop_o  = drop_q;
    assign busy_o  = (cnt_q != '0) | valid_q;

endmodule

// File: tb/tb_peasant_dot_acc.sv
// Scoreboard bench for peasant_dot_acc: two instances (G=4 and G=1) share stimulus,
// per-instance monitors pop hand-computed expected sums on every transfer.
module tb_peasant_dot_acc;

    typedef struct {
        logic [63:0] sum;
        logic        ovf;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        flI;
    logic [31:0] prodI;
    logic        clearI;
    logic        readyI;

    logic [35:0] sumA;
    logic        validA, ovfA, dropA, busyA;
    logic [2:0]  cntA;
    logic [32:0] sumB;
    logic        validB, ovfB, dropB, busyB;
    logic [2:0]  cntB;

    int checkCount = 0;
    int failCount  = 0;

    expEntry_t expA[$];
    expEntry_t expB[$];

    always #5 clk = ~clk;

    peasant_dot_acc #(.N(16), .LEN(4), .G(4)) dutA (
        .clk_i(clk), .rst_i(rstN), .fl_i(flI), .prod_i(prodI), .clear_i(clearI),
        .sum_o(sumA), .valid_o(validA), .ready_i(readyI), .cnt_o(cntA),
        .ovf_o(ovfA), .drop_o(dropA), .busy_o(busyA)
    );

    peasant_dot_acc #(.N(16), .LEN(4), .G(1)) dutB (
        .clk_i(clk), .rst_i(rstN), .fl_i(flI), .prod_i(prodI), .clear_i(clearI),
        .sum_o(sumB), .valid_o(validB), .ready_i(readyI), .cnt_o(cntB),
        .ovf_o(ovfB), .drop_o(dropB), .busy_o(busyB)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] p);
        prodI = p;
        flI   = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        flI = 1'b0;
        repeat (n) tick();
    endtask

    task automatic feedVector(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        applyStimulus(a); idle(1);
        applyStimulus(b); idle(1);
        applyStimulus(c); idle(1);
        applyStimulus(d); idle(1);
    endtask

    task automatic expectSum(input logic [63:0] sa, input logic oa,
                             input logic [63:0] sb, input logic ob);
        expEntry_t e;
        e.sum = sa; e.ovf = oa; expA.push_back(e);
        e.sum = sb; e.ovf = ob; expB.push_back(e);
    endtask

    always @(negedge clk) begin
        expEntry_t e;
        if (rstN && validA && readyI) begin
            if (expA.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL unexpectedA: got sum 0x%0h expected no transfer", sumA);
            end else begin
                e = expA.pop_front();
                checkOutput("scoreSumA", 64'(sumA), e.sum);
                checkOutput("scoreOvfA", 64'(ovfA), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        expEntry_t e;
        if (rstN && validB && readyI) begin
            if (expB.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL unexpectedB: got sum 0x%0h expected no transfer", sumB);
            end else begin
                e = expB.pop_front();
                checkOutput("scoreSumB", 64'(sumB), e.sum);
                checkOutput("scoreOvfB", 64'(ovfB), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; flI = 1'b0; prodI = '0; clearI = 1'b0; readyI = 1'b1;
        repeat (2) tick();
        checkOutput("rstSum",   64'(sumA),   64'd0);
        checkOutput("rstValid", 64'(validA), 64'd0);
        checkOutput("rstCnt",   64'(cntA),   64'd0);
        checkOutput("rstOvf",   64'(ovfA),   64'd0);
        checkOutput("rstDrop",  64'(dropA),  64'd0);
        checkOutput("rstBusy",  64'(busyA),  64'd0);
        rstN = 1'b1;
        tick();

        $display("[TB] basic vector 3,5,7,9");
        expectSum(64'd24, 1'b0, 64'd24, 1'b0);
        applyStimulus(32'd3); checkOutput("cnt1", 64'(cntA), 64'd1); idle(1);
        applyStimulus(32'd5); checkOutput("cnt2", 64'(cntA), 64'd2); idle(1);
        applyStimulus(32'd7); checkOutput("cnt3", 64'(cntA), 64'd3);
        checkOutput("validEarly", 64'(validA), 64'd0); idle(1);
        applyStimulus(32'd9);
        checkOutput("cnt4",   64'(cntA),   64'd4);
        checkOutput("valid1", 64'(validA), 64'd1);
        checkOutput("sum24",  64'(sumA),   64'h18);
        idle(1);
        checkOutput("validOff", 64'(validA), 64'd0);
        checkOutput("cnt0",     64'(cntA),   64'd0);
        checkOutput("busyOff",  64'(busyA),  64'd0);

        $display("[TB] held flag yields one accept");
        expectSum(64'd106, 1'b0, 64'd106, 1'b0);
        prodI = 32'd100;
        flI   = 1'b1;
        repeat (10) tick();
        checkOutput("heldCnt",  64'(cntA),  64'd1);
        checkOutput("heldBusy", 64'(busyA), 64'd1);
        idle(1);
        applyStimulus(32'd1); idle(1);
        applyStimulus(32'd2); idle(1);
        applyStimulus(32'd3); idle(1);
        checkOutput("heldDone", 64'(cntA), 64'd0);

        $display("[TB] backpressure and drop");
        readyI = 1'b0;
        expectSum(64'd24, 1'b0, 64'd24, 1'b0);
        feedVector(32'd3, 32'd5, 32'd7, 32'd9);
        checkOutput("holdValid", 64'(validA), 64'd1);
        checkOutput("holdDrop0", 64'(dropA),  64'd0);
        applyStimulus(32'd11);
        idle(1);
        checkOutput("dropSet",   64'(dropA),  64'd1);
        checkOutput("holdSum",   64'(sumA),   64'd24);
        checkOutput("holdCnt",   64'(cntA),   64'd4);
        checkOutput("holdValid2",64'(validA), 64'd1);
        readyI = 1'b1;
        idle(1);
        checkOutput("xferValid", 64'(validA), 64'd0);
        checkOutput("xferCnt",   64'(cntA),   64'd0);
        checkOutput("dropSticky",64'(dropA),  64'd1);
        idle(2);
        checkOutput("dropSticky2", 64'(dropA), 64'd1);
        clearI = 1'b1;
        tick();
        clearI = 1'b0;
        checkOutput("dropCleared", 64'(dropA), 64'd0);

        $display("[TB] accept and transfer in same cycle");
        readyI = 1'b0;
        expectSum(64'd24, 1'b0, 64'd24, 1'b0);
        feedVector(32'd3, 32'd5, 32'd7, 32'd9);
        expectSum(64'd12, 1'b0, 64'd12, 1'b0);
        readyI = 1'b1;
        applyStimulus(32'd6);
        checkOutput("restartCnt",   64'(cntA),   64'd1);
        checkOutput("restartValid", 64'(validA), 64'd0);
        checkOutput("restartDrop",  64'(dropA),  64'd0);
        idle(1);
        applyStimulus(32'd1); idle(1);
        applyStimulus(32'd2); idle(1);
        applyStimulus(32'd3); idle(1);

        $display("[TB] saturation");
        expectSum(64'h3FFFFFFFC, 1'b0, 64'h1FFFFFFFF, 1'b1);
        applyStimulus(32'hFFFFFFFF); idle(1);
        applyStimulus(32'hFFFFFFFF);
        checkOutput("ovfB2", 64'(ovfB), 64'd0);
        idle(1);
        applyStimulus(32'hFFFFFFFF);
        checkOutput("ovfB3", 64'(ovfB), 64'd1);
        idle(1);
        applyStimulus(32'hFFFFFFFF);
        checkOutput("satSumB", 64'(sumB), 64'h1FFFFFFFF);
        checkOutput("satOvfB", 64'(ovfB), 64'd1);
        checkOutput("satOvfA", 64'(ovfA), 64'd0);
        checkOutput("satSumA", 64'(sumA), 64'h3FFFFFFFC);
        idle(1);
        checkOutput("ovfBClr", 64'(ovfB), 64'd0);

        $display("[TB] clear discards a concurrent product");
        applyStimulus(32'd3); idle(1);
        clearI = 1'b1;
        applyStimulus(32'd5);
        clearI = 1'b0;
        checkOutput("clrCnt",  64'(cntA),  64'd0);
        checkOutput("clrDrop", 64'(dropA), 64'd0);
        checkOutput("clrBusy", 64'(busyA), 64'd0);
        idle(1);

        $display("[TB] async reset mid-vector");
        applyStimulus(32'd3); idle(1);
        applyStimulus(32'd5); idle(1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arstCnt",  64'(cntA),   64'd0);
        checkOutput("arstSum",  64'(sumA),   64'd0);
        checkOutput("arstBusy", 64'(busyA),  64'd0);
        checkOutput("arstValid",64'(validA), 64'd0);
        tick();
        rstN = 1'b1;
        tick();
        expectSum(64'd4, 1'b0, 64'd4, 1'b0);
        feedVector(32'd1, 32'd1, 32'd1, 32'd1);
        idle(2);

        checkOutput("queueA", 64'(expA.size()), 64'd0);
        checkOutput("queueB", 64'(expB.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/peasant_dot_acc.md
Name: peasant_dot_acc

Overview:
- Downstream consumer of the shift-add (peasant) multiplier.
- Captures each finished product when the multiplier's done flag rises, and accumulates LEN products into one dot-product sum.
- Presents the sum on a valid/ready output handshake.
- Sits between the multiplier and the result bus. It also reports overflow and dropped products.

Parameters:
- N, 16, operand width of the multiplier. Product width is 2*N.
- LEN, 8, number of products per dot product (>=1).
- G, 4, accumulator guard bits. Accumulator width is AW = 2*N+G.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-low.
- fl_i, in, 1: multiplier done flag (level). A rising edge marks a new valid product.
- prod_i, in, 2*N: multiplier product. Sampled only on the accept cycle.
- clear_i, in, 1: synchronous clear of the current vector and of the sticky flags.
- sum_o, out, AW: dot-product result.
- valid_o, out, 1: sum_o is valid.
- ready_i, in, 1: consumer accepts sum_o.
- cnt_o, out, clog2(LEN+1): products accumulated in the current vector.
- ovf_o, out, 1: sticky. Accumulator saturated in the current vector.
- drop_o, out, 1: sticky. A product arrived while in HOLD and was discarded.
- busy_o, out, 1: high when cnt_o != 0 or valid_o.

Behaviour:
- Reset (rst_i=0, async): state=ACC, acc=0, cnt_o=0, sum_o=0, valid_o=0, ovf_o=0, drop_o=0, busy_o=0, fl_q=0.
- Edge detect:
  - fl_q registers fl_i every cycle, including during clear_i.
  - accept = fl_i & ~fl_q.
  - fl_i held high for many cycles yields exactly one accept.
- State ACC:
  - On accept: acc <= sat(acc + zero-extended prod_i), cnt <= cnt+1.
  - If cnt+1 == LEN: go to HOLD, sum_o <= new acc value, valid_o <= 1 on the next cycle.
  - Latency: last accept in cycle k means valid_o=1 in cycle k+1.
- State HOLD:
  - sum_o, ovf_o and cnt_o (=LEN) are held stable while valid_o=1 and ready_i=0.
  - valid_o & ready_i: transfer. Next cycle valid_o=0, acc=0, cnt=0, ovf=0, state=ACC.
  - accept without transfer in the same cycle: product discarded, drop_o <= 1.
  - accept and transfer in the same cycle: product becomes term 1 of the next vector (acc=prod, cnt=1). No drop.
- Saturation:
  - If the AW-bit add carries out: acc <= all ones and ovf_o <= 1.
  - Subsequent adds in the same vector keep acc at all ones.
  - ovf_o clears on transfer or clear_i. drop_o clears only on clear_i or reset.
- clear_i (sync, priority over accept and transfer): acc=0, cnt=0, valid_o=0, ovf_o=0, drop_o=0, state=ACC. Any product accepted in that cycle is discarded and does not set drop_o.
- LEN=1: every accept goes straight to HOLD.
- Reset mid-vector: partial sum lost. The first accept after reset release starts a new vector.
- No combinational path from ready_i or fl_i to any output.

Test Plan:
- N=16, LEN=4, G=4, ready_i=1; products 3, 5, 7, 9 each on a separate fl_i rise -> sum_o=24 (0x018), valid_o high exactly 1 cycle, cycle after 4th accept; cnt_o 1,2,3,4 then 0.
- fl_i held high 10 cycles with prod_i=100 -> single accept, cnt_o=1, acc=100.
- ready_i=0 after 4 products summing 24; a 5th product 11 arrives -> sum_o stays 24, drop_o=1; ready_i=1 -> transfer, cnt_o=0; drop_o stays 1 until clear_i.
- HOLD with sum 24; ready_i=1 in the same cycle as an accept of 6 -> transfer 24, next vector starts with cnt_o=1, acc=6, drop_o=0.
- G=1, LEN=4; four products of 0xFFFFFFFF -> sum_o=0x1FFFFFFFF (saturated), ovf_o=1; ovf_o=0 after transfer.
- After 2 products (3, 5): assert rst_i=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, then feed 4 products of 1 -> sum_o=4.
